// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Arbitrates NUM_CH request channels onto a single byte-wide RAM/IO bus.
// Each granted access (byte, half or word) is serialised little-endian, one
// byte per cycle, starting at the latched address and wrapping modulo 2^32.
// Arbitration is fixed priority (lowest index wins) or round-robin. Reads on
// channels selected by FLUSH_MASK are aborted by flush.
//
// Ports
//   clk, rst          clock, asynchronous active-low reset
//   stall             blocks new grants only (in-flight transfers finish)
//   flush             aborts masked reads, removes them from arbitration
//   ch_req/ch_wr      per-channel request and direction (1 = write)
//   ch_addr/ch_wdata  32-bit address / write data per channel, packed
//   ch_size           2 bits per channel: 0 byte, 1 half, 2/3 word
//   ch_done           one-cycle completion pulse for the granted channel
//   ch_rdata          assembled read data, zero-extended
//   grant_id          index of the currently granted channel
//   busy              high whenever the FSM is not idle
//   mem_din/mem_dout  RAM read / write byte
//   mem_a, mem_wr     RAM address and write strobe
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int                NUM_CH     = 2,
  parameter int                ARB_MODE   = 0,
  parameter logic [NUM_CH-1:0] FLUSH_MASK = NUM_CH'(1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [NUM_CH-1:0]     ch_req,
  input  logic [NUM_CH-1:0]     ch_wr,
  input  logic [32*NUM_CH-1:0]  ch_addr,
  input  logic [32*NUM_CH-1:0]  ch_wdata,
  input  logic [2*NUM_CH-1:0]   ch_size,
  output logic [NUM_CH-1:0]     ch_done,
  output logic [31:0]           ch_rdata,
  output logic [2:0]            grant_id,
  output logic                  busy,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [31:0]           mem_a,
  output logic                  mem_wr
);

  typedef enum logic [2:0] {IDLE, RD, RWAIT, WR, DONE} state_t;

  state_t              state, state_next;
  logic [2:0]          grant, rr_ptr, base, pick, cand, ptr_next;
  logic [31:0]         addr, wdata, rdata, sel_addr, sel_wdata;
  logic [1:0]          last_idx, sel_size, rd_byte;
  logic [2:0]          idx;
  logic                wr_q, sel_wr, found, take, abort, last, flushable;
  logic [NUM_CH-1:0]   elig, rot;

  // Arbitration: rotate the eligible set so that the search always starts at
  // bit 0; in fixed mode the rotation base is simply 0.
  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    elig  = ch_req & ~(FLUSH_MASK & ~ch_wr & {NUM_CH{flush}});
    base  = (ARB_MODE == 1) ? rr_ptr : 3'd0;
    rot   = NUM_CH'({elig, elig} >> base);
    found = 1'b0;
    pick  = 3'd0;
    cand  = 3'd0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = base + 3'(k);
      if (({1'b0, base} + 4'(k)) >= 4'(NUM_CH)) cand = cand - 3'(NUM_CH);
      if (!found && rot[k]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
    ptr_next  = (pick == 3'(NUM_CH - 1)) ? 3'd0 : pick + 3'd1;
    sel_addr  = 32'(ch_addr  >> {pick, 5'b00000});
    sel_wdata = 32'(ch_wdata >> {pick, 5'b00000});
    sel_size  = 2'(ch_size   >> {pick, 1'b0});
    sel_wr    = 1'(ch_wr     >> pick);
  end

  assign flushable = 1'(FLUSH_MASK >> grant);
  assign abort     = flush && flushable && !wr_q;
  assign last      = (idx[1:0] == last_idx);
  // Byte that was addressed in the previous cycle and is now on mem_din.
  assign rd_byte   = 2'(idx - 3'd1);

  // Next-state logic.
  always_comb begin
    state_next = state;
    take       = 1'b0;
    case (state)
      IDLE: begin
        if (!stall && found) begin
          take       = 1'b1;
          state_next = sel_wr ? WR : RD;
        end
      end
      WR:      if (last) state_next = DONE;
      RD: begin
        if (abort)     state_next = IDLE;
        else if (last) state_next = RWAIT;
      end
      RWAIT:   state_next = abort ? IDLE : DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bus and channel outputs, decoded from the state and latched operands.
  always_comb begin
    mem_wr   = 1'b0;
    mem_a    = 32'd0;
    mem_dout = 8'd0;
    ch_done  = '0;
    case (state)
      WR: begin
        mem_wr   = 1'b1;
        mem_a    = addr + {29'd0, idx};
        mem_dout = wdata[{idx[1:0], 3'b000} +: 8];
      end
      RD:      mem_a   = addr + {29'd0, idx};
      DONE:    ch_done = NUM_CH'(1) << grant;
      default: ;
    endcase
  end

  assign busy     = (state != IDLE);
  assign grant_id = grant;
  assign ch_rdata = rdata;

  // NOTE: state and operand registers use non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: every register, including the data/address holding registers,
    // is reset so all outputs read 0 while rst is low.
    if (!rst) begin
      state    <= IDLE;
      grant    <= 3'd0;
      rr_ptr   <= 3'd0;
      addr     <= 32'd0;
      wdata    <= 32'd0;
      rdata    <= 32'd0;
      last_idx <= 2'd0;
      idx      <= 3'd0;
      wr_q     <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (take) begin
            grant    <= pick;
            rr_ptr   <= ptr_next;
            addr     <= sel_addr;
            wdata    <= sel_wdata;
            wr_q     <= sel_wr;
            idx      <= 3'd0;
            rdata    <= 32'd0;
            last_idx <= (sel_size == 2'd0) ? 2'd0 :
                        (sel_size == 2'd1) ? 2'd1 : 2'd3;
          end
        end
        WR: idx <= idx + 3'd1;
        RD: begin
          if (idx != 3'd0) rdata[{rd_byte, 3'b000} +: 8] <= mem_din;
          idx <= idx + 3'd1;
        end
        RWAIT:   rdata[{rd_byte, 3'b000} +: 8] <= mem_din;
        default: ;
      endcase
    end
  end

endmodule
